// File: rtl/demux_2ch_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// demux_2ch_deserializer_pkg
// Shared definitions for the two-channel deserializer that sits behind the
// 1-to-2 bit demultiplexer.
//   DEFAULT_WIDTH : default word width in bits
//   CH0 / CH1     : select values that steer a bit to channel 0 / channel 1
//   ch_state_e    : per-channel output state (EMPTY / FULL)
//   cnt_width()   : ceil(log2(width)) with a minimum of 1, sizes the bit counter
// -----------------------------------------------------------------------------
package demux_2ch_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ch_state_e;

  // Smallest bit count that can hold values 0..width-1 (at least 1 bit).
  function automatic int cnt_width(input int width);
    int bits;
    bits = 1;
    for (int i = 1; i < 6; i++) begin
      if ((32'sd1 <<< i) < width) begin
        bits = i + 1;
      end else begin
        bits = bits;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/demux_2ch_deserializer_ch_deser.sv
// -----------------------------------------------------------------------------
// demux_ch_deser
// Single-channel deserializer: shift register, bit counter and an EMPTY/FULL
// output holding register with a valid/ready handshake and sticky overflow.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bit_en        : accept bit_in this cycle
//   bit_in        : serial data bit
//   ready         : consumer accepts data (ignored while EMPTY)
//   clear_ovf     : synchronous clear of overflow (a same-cycle drop wins)
//   data          : last loaded word, stable while valid and not ready
//   valid         : data holds an unconsumed word
//   overflow      : sticky, a completed word was dropped
// -----------------------------------------------------------------------------
module demux_ch_deser
  import demux_2ch_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic             ready,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overflow
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);

  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shifted_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] data_r;
  logic             overflow_r;
  logic             completion_s;
  logic             load_s;
  logic             drop_s;
  ch_state_e        state_r;
  ch_state_e        state_s;

  // Shift register value including the bit presented this cycle.
  always_comb begin
    shifted_s = shift_r;
    if (MSB_FIRST) begin
      shifted_s = {shift_r[WIDTH-2:0], bit_in};
    end else begin
      shifted_s = {bit_in, shift_r[WIDTH-1:1]};
    end
  end

  // A word completes when the WIDTH-th bit is accepted.
  assign completion_s = bit_en && (cnt_r == CNT_LAST);

  // Shift register and bit counter; the counter wraps regardless of output state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (bit_en) begin
      shift_r <= shifted_s;
      cnt_r   <= completion_s ? {CW{1'b0}} : (cnt_r + CNT_ONE);
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  // Output FSM next state: decides whether a completed word loads or is dropped.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    drop_s  = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (completion_s) begin
          state_s = ST_FULL;
          load_s  = 1'b1;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (completion_s) begin
          state_s = ST_FULL;
          // Consumer takes the old word this cycle, so the new one can replace it.
          if (ready) begin
            load_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else if (ready) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // Output FSM state, held word and sticky overflow (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_EMPTY;
      data_r     <= {WIDTH{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        data_r <= shifted_s;
      end else begin
        data_r <= data_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clear_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign data     = data_r;
  assign valid    = (state_r == ST_FULL);
  assign overflow = overflow_r;

endmodule

// File: rtl/demux_2ch_deserializer.sv
// -----------------------------------------------------------------------------
// demux_2ch_deserializer
// Reassembles the two bit streams routed by a 1-to-2 demux into WIDTH-bit words,
// one independent valid/ready output and sticky overflow flag per channel.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   bit_valid, sel          : a routed bit is present, and which channel it is for
//   out1_bit / out2_bit     : demux outputs; data for sel=0 / sel=1
//   chN_data/valid/ready    : per-channel word handshake
//   chN_overflow, clear_ovf : sticky drop flags and their shared clear
// -----------------------------------------------------------------------------
module demux_2ch_deserializer
  import demux_2ch_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             sel,
  input  logic             out1_bit,
  input  logic             out2_bit,
  output logic [WIDTH-1:0] ch0_data,
  output logic             ch0_valid,
  input  logic             ch0_ready,
  output logic [WIDTH-1:0] ch1_data,
  output logic             ch1_valid,
  input  logic             ch1_ready,
  output logic             ch0_overflow,
  output logic             ch1_overflow,
  input  logic             clear_ovf
);

  logic en0_s;
  logic en1_s;

  // Steer the bit enable to the channel named by sel; the unselected output is ignored.
  always_comb begin
    en0_s = 1'b0;
    en1_s = 1'b0;
    if (bit_valid) begin
      case (sel)
        CH0:     en0_s = 1'b1;
        CH1:     en1_s = 1'b1;
        default: begin
          en0_s = 1'b0;
          en1_s = 1'b0;
        end
      endcase
    end else begin
      en0_s = 1'b0;
      en1_s = 1'b0;
    end
  end

  demux_ch_deser #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_ch0 (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (en0_s),
    .bit_in    (out1_bit),
    .ready     (ch0_ready),
    .clear_ovf (clear_ovf),
    .data      (ch0_data),
    .valid     (ch0_valid),
    .overflow  (ch0_overflow)
  );

  demux_ch_deser #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_ch1 (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (en1_s),
    .bit_in    (out2_bit),
    .ready     (ch1_ready),
    .clear_ovf (clear_ovf),
    .data      (ch1_data),
    .valid     (ch1_valid),
    .overflow  (ch1_overflow)
  );

endmodule

// File: tb/tb_demux_2ch_deserializer.sv
// -----------------------------------------------------------------------------
// tb_demux_2ch_deserializer
// Directed bench for demux_2ch_deserializer. Two instances share the stimulus:
// dut (WIDTH=8, MSB_FIRST=1) and dut_l (WIDTH=8, MSB_FIRST=0).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_demux_2ch_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_valid;
  logic       sel;
  logic       out1_bit;
  logic       out2_bit;
  logic       ch0_ready;
  logic       ch1_ready;
  logic       clear_ovf;

  logic [7:0] ch0_data;
  logic       ch0_valid;
  logic [7:0] ch1_data;
  logic       ch1_valid;
  logic       ch0_overflow;
  logic       ch1_overflow;

  logic [7:0] l_ch0_data;
  logic       l_ch0_valid;
  logic [7:0] l_ch1_data;
  logic       l_ch1_valid;
  logic       l_ch0_overflow;
  logic       l_ch1_overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux_2ch_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .sel(sel),
    .out1_bit(out1_bit), .out2_bit(out2_bit),
    .ch0_data(ch0_data), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
    .ch0_overflow(ch0_overflow), .ch1_overflow(ch1_overflow),
    .clear_ovf(clear_ovf)
  );

  demux_2ch_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .sel(sel),
    .out1_bit(out1_bit), .out2_bit(out2_bit),
    .ch0_data(l_ch0_data), .ch0_valid(l_ch0_valid), .ch0_ready(ch0_ready),
    .ch1_data(l_ch1_data), .ch1_valid(l_ch1_valid), .ch1_ready(ch1_ready),
    .ch0_overflow(l_ch0_overflow), .ch1_overflow(l_ch1_overflow),
    .clear_ovf(clear_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, wait for the edge, settle 1 unit.
  task automatic cyc(input logic v, input logic s, input logic o1, input logic o2);
    bit_valid = v;
    sel       = s;
    out1_bit  = o1;
    out2_bit  = o2;
    @(posedge clk);
    #1;
  endtask

  // Send bit positions [first, last) of w to channel s; the other demux output
  // carries the inverted bit so that a wrong steering would corrupt data.
  task automatic send_bits(input logic s, input logic [7:0] w, input logic lsb_first,
                           input int first, input int last);
    logic b;
    for (int i = first; i < last; i++) begin
      b = lsb_first ? w[i] : w[7-i];
      cyc(1'b1, s, s ? ~b : b, s ? b : ~b);
    end
  endtask

  initial begin
    logic [7:0] w0;
    logic [7:0] w1;
    logic       b;

    rst = 1'b1; bit_valid = 1'b0; sel = 1'b0; out1_bit = 1'b0; out2_bit = 1'b0;
    ch0_ready = 1'b1; ch1_ready = 1'b1; clear_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_ch0_data", ch0_data, 8'h00);
    chk("rst_ch0_valid", ch0_valid, 1'b0);
    chk("rst_ch1_data", ch1_data, 8'h00);
    chk("rst_ch1_valid", ch1_valid, 1'b0);
    chk("rst_ch0_ovf", ch0_overflow, 1'b0);
    chk("rst_ch1_ovf", ch1_overflow, 1'b0);

    // Single word 0xA5 on ch0, valid exactly after the 8th bit
    send_bits(1'b0, 8'hA5, 1'b0, 0, 7);
    chk("a5_valid_early", ch0_valid, 1'b0);
    send_bits(1'b0, 8'hA5, 1'b0, 7, 8);
    chk("a5_valid", ch0_valid, 1'b1);
    chk("a5_data", ch0_data, 8'hA5);
    chk("a5_ch1_quiet", ch1_valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_consumed", ch0_valid, 1'b0);

    // Interleaved ch0=0x3C, ch1=0xF0 with out2 toggling during ch0 bits
    ch0_ready = 1'b0; ch1_ready = 1'b0;
    w0 = 8'h3C; w1 = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      b = w0[7-i];
      cyc(1'b1, 1'b0, b, i[0]);
      b = w1[7-i];
      cyc(1'b1, 1'b1, ~b, b);
    end
    chk("il_ch0_valid", ch0_valid, 1'b1);
    chk("il_ch0_data", ch0_data, 8'h3C);
    chk("il_ch1_valid", ch1_valid, 1'b1);
    chk("il_ch1_data", ch1_data, 8'hF0);
    ch0_ready = 1'b1; ch1_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("il_ch0_drain", ch0_valid, 1'b0);
    chk("il_ch1_drain", ch1_valid, 1'b0);

    // Backpressure: 0x11 held, 0x22 dropped
    ch0_ready = 1'b0;
    send_bits(1'b0, 8'h11, 1'b0, 0, 8);
    chk("bp_first_data", ch0_data, 8'h11);
    send_bits(1'b0, 8'h22, 1'b0, 0, 8);
    chk("bp_hold_data", ch0_data, 8'h11);
    chk("bp_hold_valid", ch0_valid, 1'b1);
    chk("bp_ovf", ch0_overflow, 1'b1);
    chk("bp_ch1_ovf", ch1_overflow, 1'b0);
    ch0_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    clear_ovf = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    clear_ovf = 1'b0;
    chk("bp_cleared", ch0_overflow, 1'b0);
    chk("bp_drained", ch0_valid, 1'b0);

    // Backpressure released on the completing cycle: 0x22 replaces 0x11
    ch0_ready = 1'b0;
    send_bits(1'b0, 8'h11, 1'b0, 0, 8);
    send_bits(1'b0, 8'h22, 1'b0, 0, 7);
    ch0_ready = 1'b1;
    send_bits(1'b0, 8'h22, 1'b0, 7, 8);
    chk("rl_data", ch0_data, 8'h22);
    chk("rl_valid", ch0_valid, 1'b1);
    chk("rl_ovf", ch0_overflow, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rl_drained", ch0_valid, 1'b0);

    // clear_ovf coincident with an overflow: set wins
    ch0_ready = 1'b0;
    send_bits(1'b0, 8'h11, 1'b0, 0, 8);
    send_bits(1'b0, 8'h22, 1'b0, 0, 7);
    clear_ovf = 1'b1;
    send_bits(1'b0, 8'h22, 1'b0, 7, 8);
    clear_ovf = 1'b0;
    chk("co_set_wins", ch0_overflow, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("co_sticky", ch0_overflow, 1'b1);
    clear_ovf = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    clear_ovf = 1'b0;
    chk("co_cleared", ch0_overflow, 1'b0);
    chk("co_data_kept", ch0_data, 8'h11);
    ch0_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-word on ch1: partial bits discarded
    send_bits(1'b1, 8'h00, 1'b0, 0, 5);
    rst = 1'b1;
    #1;
    chk("mr_async_ch0_data", ch0_data, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_bits(1'b1, 8'hFF, 1'b0, 0, 7);
    chk("mr_no_early_valid", ch1_valid, 1'b0);
    send_bits(1'b1, 8'hFF, 1'b0, 7, 8);
    chk("mr_valid", ch1_valid, 1'b1);
    chk("mr_data", ch1_data, 8'hFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Gaps, LSB-first instance: 0x96 with random idle cycles between bits
    ch0_ready = 1'b0;
    w0 = 8'h96;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b1, 1'b1);
      if (i == 7) chk("gap_no_early_valid", l_ch0_valid, 1'b0);
      cyc(1'b1, 1'b0, w0[i], ~w0[i]);
    end
    chk("gap_l_valid", l_ch0_valid, 1'b1);
    chk("gap_l_data", l_ch0_data, 8'h96);
    chk("gap_msb_data", ch0_data, 8'h69);
    chk("gap_l_ch1_quiet", l_ch1_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
